dtree_feature_loader: RTL and testbench
=======================================

// Module: dtree_feature_loader
// PURPOSE
//  Upstream front end for the printed decision-tree classifiers. Accepts one
//  feature per beat on a valid/ready byte stream, assembles a frame of N_FEAT
//  features, then holds the vector stable on a flat bus for the combinational
//  tree until the downstream class-capture stage acknowledges it.
//  Frames with bad framing are detected, flagged and discarded.
// PARAMETERS
//  N_FEAT   7    features per frame; tree input order, index 0 first
//  W        8    bits per feature
//  CNT_W    16   width of the accepted-frame counter
// PORTS
//  clk          in   1          clock; all state updates on the rising edge
//  rst_n        in   1          asynchronous active-low reset
//  in_valid     in   1          upstream feature beat valid
//  in_ready     out  1          loader can accept a beat
//  in_data      in   W          feature value, unsigned
//  in_last      in   1          beat is the last feature of the frame
//  feat_flat    out  N_FEAT*W   feature k on feat_flat[k*W +: W]
//  feat_valid   out  1          feat_flat holds a complete frame
//  feat_ack     in   1          consumer has latched its class; release frame
//  frame_err    out  1          one-cycle pulse: a frame was discarded
//  frame_cnt    out  CNT_W      count of frames delivered; wraps to 0
// BEHAVIOUR
//  Reset values: state LOAD; idx 0; feat_flat 0; feat_valid 0; frame_err 0;
//   frame_cnt 0. Asynchronous reset mid-frame drops the partial frame. No
//   error is flagged.
//  A beat transfers when in_valid && in_ready. in_ready is decoded from state
//   only: 1 in LOAD and DRAIN, 0 in FULL. It never depends on in_valid.
//  States:
//   LOAD  on a beat, write in_data into slot idx.
//         in_last && idx==N_FEAT-1: go to FULL, idx<=0.
//         in_last && idx<N_FEAT-1 (short frame): frame_err pulse, idx<=0,
//          stay in LOAD.
//         !in_last && idx==N_FEAT-1 (long frame): frame_err pulse, idx<=0,
//          go to DRAIN.
//         Otherwise idx<=idx+1.
//   FULL  feat_valid=1 and feat_flat frozen.
//         feat_ack: go to LOAD and increment frame_cnt (modulo 2^CNT_W).
//          feat_valid drops the next cycle.
//         feat_ack outside FULL is ignored.
//   DRAIN discard beats. A beat with in_last goes to LOAD. No further
//          frame_err pulses.
//  Slot writes are in-place; only the written slot changes. feat_flat is
//   registered and has no combinational path from in_data.
//   A short frame can leave stale slots. These are not visible because
//   feat_valid is 0 outside FULL.
//  Latency: a frame's last beat at edge t gives feat_valid=1 after edge t.
//   feat_ack at edge t+k gives in_ready=1 after edge t+k.
//   Peak throughput is one frame per N_FEAT+1 cycles with a same-cycle ack.
//  frame_err is a registered single-cycle pulse, asserted the cycle after the
//   offending beat.
//  N_FEAT==1: every beat needs in_last=1, else the long-frame rule applies.
// STRUCTURE
//  Shared package dtree_pkg: state enum {LOAD, FULL, DRAIN}; default
//   N_FEAT/W; IDX_W = $clog2(N_FEAT) with a minimum of 1.
//  Single sequential module, no sub-modules. The FSM, index counter and slot
//   register array are small enough to stay flat.
// TESTING
//  Frame 0x11..0x77 (in_last on the 7th beat), ack held high ->
//   feat_flat = 0x77665544332211, one feat_valid cycle, frame_cnt=1.
//  Same frame with ack withheld 20 cycles -> in_ready=0 and feat_flat stable
//   throughout. On ack, in_ready=1 the next cycle.
//  in_last on the 3rd beat -> frame_err pulses once, no feat_valid.
//   The following 7-beat frame delivers correctly.
//  9-beat frame, in_last on the 9th -> frame_err once at beat 7, beats 8-9
//   dropped. The next frame is delivered correctly.
//  rst_n low mid-frame (after beat 4) -> all outputs return to reset values
//   asynchronously. The next full frame is delivered correctly.
//  Preload frame_cnt to 0xFFFF and deliver one frame -> frame_cnt=0x0000.

Source files
------------

// File: rtl/dtree_pkg.sv
// Shared definitions for the decision-tree feature loader.
//  - loader FSM state encoding
//  - default frame geometry (features per frame, feature width, counter width)
//  - helper to size the slot index so that a single-feature frame still gets
//    a 1-bit index instead of a zero-width vector
package dtree_pkg;

  localparam int DEF_N_FEAT = 7;
  localparam int DEF_W      = 8;
  localparam int DEF_CNT_W  = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_w(DEF_N_FEAT);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/dtree_feature_loader.sv
// dtree_feature_loader
//  Collects one feature per beat from a valid/ready stream into N_FEAT slots,
//  then presents the assembled vector on feat_flat (feature k at
//  feat_flat[k*W +: W]) with feat_valid high until feat_ack releases it.
//  Frames whose in_last does not land on beat N_FEAT are discarded and
//  reported with a one-cycle frame_err pulse.
// Ports
//  clk, rst_n            clock, asynchronous active-low reset
//  in_valid/in_ready     upstream handshake; in_data, in_last ride with it
//  feat_flat, feat_valid assembled frame and its qualifier
//  feat_ack              consumer release of the held frame
//  frame_err             registered single-cycle discard pulse
//  frame_cnt             delivered-frame count, wraps modulo 2^CNT_W
// Handshake: a beat moves on a rising edge where in_valid && in_ready.
//  in_ready is a pure decode of the state register and never looks at
//  in_valid, so the producer may hold in_valid high while waiting.
module dtree_feature_loader
  import dtree_pkg::*;
#(
  parameter int N_FEAT = DEF_N_FEAT,
  parameter int W      = DEF_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_data,
  input  logic                in_last,
  output logic [N_FEAT*W-1:0] feat_flat,
  output logic                feat_valid,
  input  logic                feat_ack,
  output logic                frame_err,
  output logic [CNT_W-1:0]    frame_cnt
);

  localparam int SLOT_IDX_W = idx_w(N_FEAT);
  localparam logic [SLOT_IDX_W-1:0] LAST_IDX = SLOT_IDX_W'(N_FEAT - 1);

  state_e                  state_q, state_d;
  logic [SLOT_IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]            slots_q [N_FEAT];
  logic [W-1:0]            slots_d [N_FEAT];
  logic                    frame_err_q, frame_err_d;
  logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic                    beat;

  assign in_ready   = (state_q != FULL);
  assign feat_valid = (state_q == FULL);
  assign beat       = in_valid && in_ready;
  assign frame_err  = frame_err_q;
  assign frame_cnt  = frame_cnt_q;

  // feat_flat comes straight from the slot registers, so nothing on in_data
  // can reach the tree combinationally.
  always_comb begin
    feat_flat = '0;
    for (int k = 0; k < N_FEAT; k++) begin
      feat_flat[k*W +: W] = slots_q[k];
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    for (int k = 0; k < N_FEAT; k++) begin
      slots_d[k] = slots_q[k];
    end

    unique case (state_q)
      LOAD: begin
        if (beat) begin
          // Write only the addressed slot; a short frame may leave older
          // values in higher slots, harmless since feat_valid stays low.
          for (int k = 0; k < N_FEAT; k++) begin
            if (idx_q == SLOT_IDX_W'(k)) slots_d[k] = in_data;
          end
          if (in_last) begin
            idx_d = '0;
            if (idx_q == LAST_IDX) state_d = FULL;
            else                   frame_err_d = 1'b1;
          end else if (idx_q == LAST_IDX) begin
            // Too many beats: flag once here, swallow the rest in DRAIN.
            frame_err_d = 1'b1;
            idx_d       = '0;
            state_d     = DRAIN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (feat_ack) begin
          state_d     = LOAD;
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (beat && in_last) state_d = LOAD;
      end
      default: begin
        state_d = LOAD;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
      for (int k = 0; k < N_FEAT; k++) begin
        slots_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
      for (int k = 0; k < N_FEAT; k++) begin
        slots_q[k] <= slots_d[k];
      end
    end
  end

endmodule

// File: tb/tb_dtree_feature_loader.sv
// Bench for dtree_feature_loader. A second instance with a 3-bit frame
// counter shares every input so counter wrap-around is reached quickly.
module tb_dtree_feature_loader;

  localparam int NF = 7;
  localparam int W  = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic [NF*W-1:0] feat_flat;
  logic          feat_valid;
  logic          feat_ack;
  logic          frame_err;
  logic [15:0]   frame_cnt;

  logic          in_ready_s;
  logic [NF*W-1:0] feat_flat_s;
  logic          feat_valid_s;
  logic          frame_err_s;
  logic [2:0]    frame_cnt_s;

  dtree_feature_loader dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .feat_flat(feat_flat), .feat_valid(feat_valid), .feat_ack(feat_ack),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  dtree_feature_loader #(.CNT_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .in_last(in_last),
    .feat_flat(feat_flat_s), .feat_valid(feat_valid_s), .feat_ack(feat_ack),
    .frame_err(frame_err_s), .frame_cnt(frame_cnt_s)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int model_cnt;
  logic [NF*W-1:0] exp_q [$];
  logic [W-1:0]    frame_q [$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic last, output logic err);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick;
      n++;
    end
    if (n == 20) check("ready_timeout", 64'd0, 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick;
    err      = frame_err;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = W'($urandom);
  endtask

  // Frame-level reference: a frame is delivered only if exactly NF beats
  // carry in_last on the final one; otherwise one error pulse follows the
  // beat where the framing is first known to be wrong (the short frame's
  // last beat, or beat NF of a long one) and nothing is delivered.
  task automatic run_frame(input int ack_wait, input bit ack_early, input bit bubbles);
    int len;
    int err_at;
    bit deliver;
    logic err;
    logic [NF*W-1:0] exp;
    logic [NF*W-1:0] got;
    len     = frame_q.size();
    deliver = (len == NF);
    err_at  = (len < NF) ? len - 1 : NF - 1;
    exp     = '0;
    for (int k = 0; k < NF && k < len; k++) exp[k*W +: W] = frame_q[k];
    if (deliver) exp_q.push_back(exp);
    feat_ack = ack_early;
    for (int i = 0; i < len; i++) begin
      if (bubbles && $urandom_range(0, 3) == 0) tick;
      send_beat(frame_q[i], (i == len - 1), err);
      check("frame_err", {63'd0, err}, {63'd0, (!deliver && i == err_at)});
      if (i < len - 1) check("feat_valid_mid", {63'd0, feat_valid}, 64'd0);
    end
    if (deliver) begin
      got = exp_q.pop_front();
      check("feat_valid_full", {63'd0, feat_valid}, 64'd1);
      check("in_ready_full", {63'd0, in_ready}, 64'd0);
      check("feat_flat", {8'd0, feat_flat}, {8'd0, got});
      if (!ack_early) begin
        for (int c = 0; c < ack_wait; c++) begin
          in_valid = 1'b1;
          in_data  = W'($urandom);
          in_last  = 1'($urandom);
          tick;
          check("hold_flat", {8'd0, feat_flat}, {8'd0, got});
          check("hold_ready", {63'd0, in_ready}, 64'd0);
          check("hold_valid", {63'd0, feat_valid}, 64'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        feat_ack = 1'b1;
      end
      tick;
      feat_ack = 1'b0;
      model_cnt++;
      check("valid_after_ack", {63'd0, feat_valid}, 64'd0);
      check("ready_after_ack", {63'd0, in_ready}, 64'd1);
      check("frame_cnt", {48'd0, frame_cnt}, {48'd0, 16'(model_cnt)});
      check("frame_cnt_small", {61'd0, frame_cnt_s}, {61'd0, 3'(model_cnt)});
    end else begin
      feat_ack = 1'b0;
      tick;
      check("err_single", {63'd0, frame_err}, 64'd0);
      check("no_valid_bad", {63'd0, feat_valid}, 64'd0);
      check("ready_after_bad", {63'd0, in_ready}, 64'd1);
    end
  endtask

  task automatic fill_seq(input int len);
    frame_q.delete();
    for (int k = 0; k < len; k++) frame_q.push_back(W'(8'h11 * (k + 1)));
  endtask

  initial begin
    logic err;
    int len;
    total     = 0;
    bad       = 0;
    model_cnt = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    feat_ack  = 1'b0;

    // reset values
    tick;
    tick;
    check("rst_ready", {63'd0, in_ready}, 64'd1);
    check("rst_valid", {63'd0, feat_valid}, 64'd0);
    check("rst_flat", {8'd0, feat_flat}, 64'd0);
    check("rst_err", {63'd0, frame_err}, 64'd0);
    check("rst_cnt", {48'd0, frame_cnt}, 64'd0);
    rst_n = 1'b1;
    tick;

    // 0x11..0x77 with ack high throughout
    fill_seq(NF);
    run_frame(0, 1'b1, 1'b0);

    // same frame, ack withheld 20 cycles
    fill_seq(NF);
    run_frame(20, 1'b0, 1'b0);

    // short frame (in_last on beat 3), then a good frame
    fill_seq(3);
    run_frame(0, 1'b0, 1'b0);
    fill_seq(NF);
    for (int k = 0; k < NF; k++) frame_q[k] = W'(8'hA0 + k);
    run_frame(2, 1'b0, 1'b0);

    // 9-beat frame, then a good frame
    fill_seq(9);
    run_frame(0, 1'b0, 1'b0);
    fill_seq(NF);
    run_frame(1, 1'b0, 1'b0);

    // asynchronous reset after beat 4
    for (int k = 0; k < 4; k++) send_beat(W'(8'hC0 + k), 1'b0, err);
    #2;
    rst_n = 1'b0;
    #1;
    model_cnt = 0;
    check("arst_ready", {63'd0, in_ready}, 64'd1);
    check("arst_valid", {63'd0, feat_valid}, 64'd0);
    check("arst_flat", {8'd0, feat_flat}, 64'd0);
    check("arst_err", {63'd0, frame_err}, 64'd0);
    check("arst_cnt", {48'd0, frame_cnt}, 64'd0);
    check("arst_cnt_small", {61'd0, frame_cnt_s}, 64'd0);
    #2;
    rst_n = 1'b1;
    tick;
    fill_seq(NF);
    run_frame(0, 1'b0, 1'b0);

    // back-to-back frames with same-cycle ack: drives the 3-bit counter
    // through its wrap to 0
    for (int f = 0; f < 8; f++) begin
      frame_q.delete();
      for (int k = 0; k < NF; k++) frame_q.push_back(W'($urandom));
      run_frame(0, 1'b1, 1'b0);
    end

    // randomized frames: lengths 1..10, bubbles, random ack timing
    for (int f = 0; f < 40; f++) begin
      len = ($urandom_range(0, 1) == 1) ? NF : int'($urandom_range(1, 10));
      frame_q.delete();
      for (int k = 0; k < len; k++) frame_q.push_back(W'($urandom));
      run_frame(int'($urandom_range(0, 4)), 1'($urandom), 1'b1);
    end

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
